alu_result_stage: RTL

//  Registered output stage directly downstream of the per-bit 8:1 result multiplexers of the 32-bit ALU.
//  - Captures the selected 32-bit result, derives status flags, and presents both on a valid/ready interface.
//  - A 2-entry skid buffer lets the consumer stall without combinational ready paths back into the ALU.
//  - Counts completed transfers.

---
 rtl/alu_result_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the ALU's 8:1 result muxes.
// Captures result plus status flags at push time and presents them on a
// valid/ready interface through a 2-entry skid buffer (output entry + skid
// entry), so out_ready never reaches in_ready combinationally.
// Counts output handshakes in xfer_cnt.
// Optional feature: define ALU_PARITY_EN to add the stored out_parity flag.
module alu_result_stage #(
  parameter int         WIDTH   = 32,
  parameter int         CNT_W   = 16,
  parameter logic [2:0] SEL_ADD = 3'b010,
  parameter logic [2:0] SEL_SUB = 3'b110
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [2:0]       in_sel,
  input  logic             in_cout,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_overflow,
`ifdef ALU_PARITY_EN
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  // One buffered result with the flags derived when it was pushed.
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             overflow;
`ifdef ALU_PARITY_EN
    logic             parity;
`endif
  } entry_t;

  state_t     state_q, state_d;
  entry_t     out_q, skid_q, new_entry;
  logic       push, pop;
  logic       load_out, load_skid, move_skid;
  logic       is_arith;
  logic [CNT_W-1:0] cnt_q;

  // Handshake qualifiers; ready/valid are decodes of the state register only.
  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Build the entry that would be stored on a push; carry/overflow only
  // mean something for add and subtract.
  always_comb begin
    is_arith           = (in_sel == SEL_ADD) || (in_sel == SEL_SUB);
    new_entry          = '0;
    new_entry.result   = in_result;
    new_entry.zero     = (in_result == '0);
    new_entry.neg      = in_result[WIDTH-1];
    new_entry.carry    = is_arith & in_cout;
    new_entry.overflow = is_arith & in_ovf;
`ifdef ALU_PARITY_EN
    new_entry.parity   = ^in_result;
`endif
  end

  // Next-state and entry load controls.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          state_d  = S_ONE;
          load_out = 1'b1;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          load_out = 1'b1;
        end else if (push) begin
          state_d   = S_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_d   = S_ONE;
          move_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // State register; reset discards both entries.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // Output entry: the registers that drive out_*.
  always_ff @(posedge clk) begin
    if (reset)          out_q <= '0;
    else if (load_out)  out_q <= new_entry;
    else if (move_skid) out_q <= skid_q;
  end

  // Skid entry, only written when the stage goes ONE -> FULL.
  always_ff @(posedge clk) begin
    // NOTE: the skid entry has no reset; it is never observed until written, and the state register marks it invalid.
    if (load_skid) skid_q <= new_entry;
  end

  // Transfer counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset)    cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + 1'b1;
  end

  assign out_result   = out_q.result;
  assign out_zero     = out_q.zero;
  assign out_neg      = out_q.neg;
  assign out_carry    = out_q.carry;
  assign out_overflow = out_q.overflow;
`ifdef ALU_PARITY_EN
  assign out_parity   = out_q.parity;
`endif
  assign xfer_cnt     = cnt_q;

endmodule
